// File: rtl/i2c_slave_responder_if.sv
// I2C bus-side signal bundle for i2c_slave_responder: line levels in, open-drain SDA pull-down out.
// Member names match the responder's port names so a bench can wire one straight to the other.
interface i2c_slave_responder_if;
    logic scl_i;
    logic sda_i;
    logic sda_oen;

    modport master (output scl_i, output sda_i, input sda_oen);
    modport slave  (input scl_i, input sda_i, output sda_oen);
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target with a small 8-bit register file: register-pointer writes, auto-incrementing
// reads and writes, open-drain SDA via sda_oen, all sampled from oversampled SCL/SDA on pclk.
module i2c_slave_responder #(
    parameter logic [6:0]  SLAVE_ADDRESS = 7'h68,
    parameter int unsigned NO_OF_REG     = 4
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oen,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_index,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_index,
    output logic [7:0] dbg_data
);
    localparam int unsigned IW = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t          r_state;
    logic            r_scl_s1, r_scl_s2, r_scl_d;
    logic            r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_rw;
    logic            r_phase;
    logic [IW-1:0]   r_ptr;
    logic [7:0]      r_regs [NO_OF_REG];
    logic            r_sda_oen, r_busy, r_wr_strobe;
    logic [7:0]      r_wr_index, r_wr_data;

    logic            w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]      w_byte;
    logic [IW-1:0]   w_ptr_next;
    logic [7:0]      w_dbg;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= '1;
            {r_sda_s1, r_sda_s2, r_sda_d} <= '1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_ptr_next = (32'(r_ptr) == NO_OF_REG - 1) ? '0 : IW'(32'(r_ptr) + 32'd1);

    // ACK states use r_phase: first SCL fall drives the ACK, second fall ends the slot.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_ptr       <= '0;
            r_sda_oen   <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
            r_wr_data   <= '0;
            for (int unsigned i = 0; i < NO_OF_REG; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state   <= ADDR;
                r_bitcnt  <= '0;
                r_sda_oen <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state   <= IDLE;
                r_sda_oen <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, REG, WR_DATA: if (w_scl_rise) begin
                        r_shift  <= w_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_phase  <= 1'b0;
                        if (r_bitcnt == 3'd7) begin
                            if (r_state == ADDR) begin
                                if (w_byte[7:1] == SLAVE_ADDRESS) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= ADDR_ACK;
                                end else begin
                                    r_state <= IGNORE;
                                end
                            end else if (r_state == REG) begin
                                if (32'(w_byte) < NO_OF_REG) begin
                                    r_ptr   <= IW'(w_byte);
                                    r_state <= REG_ACK;
                                end else begin
                                    r_state <= IGNORE;
                                end
                            end else begin
                                r_regs[r_ptr] <= w_byte;
                                r_wr_strobe   <= 1'b1;
                                r_wr_index    <= 8'(r_ptr);
                                r_wr_data     <= w_byte;
                                r_ptr         <= w_ptr_next;
                                r_state       <= WR_ACK;
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, WR_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_sda_oen <= 1'b1;
                            r_phase   <= 1'b1;
                        end else begin
                            r_phase  <= 1'b0;
                            r_bitcnt <= '0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                r_sda_oen <= ~r_regs[r_ptr][7];
                                r_shift   <= {r_regs[r_ptr][6:0], 1'b0};
                                r_state   <= RD_DATA;
                            end else begin
                                r_sda_oen <= 1'b0;
                                r_state   <= (r_state == ADDR_ACK) ? REG : WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (w_scl_fall) begin
                            r_sda_oen <= ~r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end else if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= RD_ACK;
                                r_phase <= 1'b0;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_fall && !r_phase) begin
                            r_sda_oen <= 1'b0;
                            r_phase   <= 1'b1;
                        end else if (w_scl_rise && r_phase) begin
                            // Next byte is preloaded here; RD_DATA drives its MSB on the coming fall.
                            r_ptr    <= w_ptr_next;
                            r_bitcnt <= '0;
                            if (!r_sda_s2) begin
                                r_shift <= r_regs[w_ptr_next];
                                r_state <= RD_DATA;
                            end else begin
                                r_state <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_dbg = '0;
        if (32'(dbg_index) < NO_OF_REG) w_dbg = r_regs[IW'(dbg_index)];
    end

    assign sda_oen   = r_sda_oen;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_index  = r_wr_index;
    assign wr_data   = r_wr_data;
    assign dbg_data  = w_dbg;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master drives directed and random
// transactions; a register/pointer model predicts ACKs, read data, write strobes and readback.
module tb_i2c_slave_responder;
    localparam logic [6:0]  ADDR = 7'h68;
    localparam int unsigned NREG = 4;
    localparam int unsigned H    = 6;

    logic       pclk, areset, m_scl, m_sda;
    logic       busy, wr_strobe;
    logic [7:0] wr_index, wr_data, dbg_index, dbg_data;

    i2c_slave_responder_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oen;

    i2c_slave_responder #(.SLAVE_ADDRESS(ADDR), .NO_OF_REG(NREG)) u_dut (
        .pclk      (pclk),
        .areset    (areset),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .sda_oen   (bus.sda_oen),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .dbg_index (dbg_index),
        .dbg_data  (dbg_data)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  m_regs [NREG];
    int unsigned m_ptr;
    logic [7:0]  dbuf [4];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        prev_oen, oen_seen;
    int unsigned viol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (wr_strobe) got_q.push_back({wr_index, wr_data});
        if (bus.sda_oen) oen_seen = 1'b1;
        if (areset && m_scl && (bus.sda_oen !== prev_oen)) viol++;
        prev_oen = bus.sda_oen;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic wt(input int unsigned n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H);
        m_sda = 1'b0; wt(H);
        m_scl = 1'b0; wt(H);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wt(H);
        m_scl = 1'b1; wt(H);
        m_sda = 1'b1; wt(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wt(H);
            m_scl = 1'b1; wt(H);
            m_scl = 1'b0;
        end
        m_sda = 1'b1; wt(H);
        m_scl = 1'b1; wt(H / 2);
        acked = ~bus.sda_i;
        wt(H - H / 2);
        m_scl = 1'b0;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wt(H);
            m_scl = 1'b1; wt(H / 2);
            b[i] = bus.sda_i;
            wt(H - H / 2);
            m_scl = 1'b0;
        end
        m_sda = master_ack ? 1'b0 : 1'b1; wt(H);
        m_scl = 1'b1; wt(H);
        m_scl = 1'b0; wt(1);
        m_sda = 1'b1;
    endtask

    task automatic compare_strobes();
        check("strobe_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("strobe_idx_data", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_dbg();
        for (int i = 0; i < 6; i++) begin
            dbg_index = 8'(i);
            #1;
            if (i < NREG) check("dbg_data", dbg_data, m_regs[i]);
            else          check("dbg_data_oob", dbg_data, 0);
        end
    endtask

    task automatic txn_write(input logic [7:0] rb, input int unsigned n);
        logic a, ok;
        i2c_start();
        check("busy_on", busy, 1);
        send_byte({ADDR, 1'b0}, a);
        check("wr_addr_ack", a, 1);
        ok = (rb < NREG);
        send_byte(rb, a);
        check("wr_reg_ack", a, ok);
        if (ok) m_ptr = rb;
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(dbuf[i], a);
            check("wr_data_ack", a, ok);
            if (ok) begin
                m_regs[m_ptr] = dbuf[i];
                exp_q.push_back({8'(m_ptr), dbuf[i]});
                m_ptr = (m_ptr + 1) % NREG;
            end
        end
        i2c_stop();
        check("busy_off", busy, 0);
        compare_strobes();
    endtask

    task automatic txn_read(input int unsigned n, input logic set_ptr, input logic [7:0] rb);
        logic a;
        logic [7:0] b;
        if (set_ptr) begin
            i2c_start();
            send_byte({ADDR, 1'b0}, a);
            check("rd_waddr_ack", a, 1);
            send_byte(rb, a);
            check("rd_reg_ack", a, rb < NREG);
            if (rb < NREG) m_ptr = rb;
        end
        i2c_start();
        send_byte({ADDR, 1'b1}, a);
        check("rd_addr_ack", a, 1);
        for (int unsigned i = 0; i < n; i++) begin
            recv_byte(i != n - 1, b);
            check("rd_data", b, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NREG;
        end
        check("rd_release", bus.sda_oen, 0);
        i2c_stop();
        compare_strobes();
    endtask

    task automatic txn_mismatch(input logic [6:0] ma, input logic [7:0] d);
        logic a;
        oen_seen = 1'b0;
        i2c_start();
        send_byte({ma, 1'b0}, a);
        check("mm_addr_nack", a, 0);
        send_byte(d, a);
        check("mm_data_nack", a, 0);
        check("mm_busy_on", busy, 1);
        i2c_stop();
        check("mm_busy_off", busy, 0);
        check("mm_oen_never", oen_seen, 0);
        compare_strobes();
    endtask

    initial begin
        logic a;
        logic [6:0] ma;
        viol = 0; prev_oen = 1'b0; oen_seen = 1'b0; m_ptr = 0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        areset = 1'b0; m_scl = 1'b1; m_sda = 1'b1; dbg_index = 8'h00;
        wt(5);
        check("rst_oen", bus.sda_oen, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_index", wr_index, 0);
        check("rst_wr_data", wr_data, 0);
        check_dbg();
        areset = 1'b1;
        wt(5);

        dbuf[0] = 8'hA5;
        txn_write(8'h01, 1);
        check_dbg();
        txn_read(2, 1'b1, 8'h01);
        txn_mismatch(7'h6C, 8'h55);
        dbuf[0] = 8'h99;
        txn_write(8'h07, 1);
        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        txn_write(8'h03, 2);
        check_dbg();

        for (int k = 0; k < 30; k++) begin
            int unsigned kind, n;
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
            case (kind)
                0: txn_write(8'($urandom_range(0, 5)), n);
                1: txn_read(n, 1'b1, 8'($urandom_range(0, 5)));
                2: txn_read(n, 1'b0, 8'h00);
                default: begin
                    ma = 7'($urandom_range(0, 127));
                    if (ma == ADDR) ma = ma ^ 7'h01;
                    txn_mismatch(ma, dbuf[0]);
                end
            endcase
        end
        check_dbg();

        dbuf[0] = 8'h00;
        txn_write(8'h00, 1);
        i2c_start();
        send_byte({ADDR, 1'b0}, a);
        send_byte(8'h00, a);
        i2c_start();
        send_byte({ADDR, 1'b1}, a);
        check("mr_addr_ack", a, 1);
        m_sda = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wt(H); m_scl = 1'b1; wt(H); m_scl = 1'b0;
        end
        wt(4);
        check("mr_pre_oen", bus.sda_oen, 1);
        areset = 1'b0;
        #1;
        check("mr_oen_async", bus.sda_oen, 0);
        check("mr_busy", busy, 0);
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        check_dbg();
        wt(5);
        m_scl = 1'b1; m_sda = 1'b1;
        wt(3);
        areset = 1'b1;
        wt(5);
        m_scl = 1'b0; wt(H);
        send_byte({ADDR, 1'b0}, a);
        check("no_start_nack", a, 0);
        compare_strobes();
        dbuf[0] = 8'h5A; dbuf[1] = 8'hC3;
        txn_write(8'h02, 2);
        check_dbg();
        check("oen_change_scl_high", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h68, the 7-bit address this target responds to.
REQ-002 SHALL have parameter NO_OF_REG, default 4, the number of 8-bit registers (DATA_WIDTH = 8); legal range 1..256.
REQ-003 SHALL have port pclk, input, 1 bit: the single clock; all logic is rising-edge pclk.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port scl_i, input, 1 bit: I2C SCL line level, asynchronous to pclk.
REQ-006 SHALL have port sda_i, input, 1 bit: I2C SDA line level, asynchronous to pclk.
REQ-007 SHALL have port sda_oen, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 SHALL have port busy, output, 1 bit: high from a detected START to the next detected STOP.
REQ-009 SHALL have port wr_strobe, output, 1 bit: one-pclk pulse per register written.
REQ-010 SHALL have port wr_index, output, 8 bits: register index of the current wr_strobe.
REQ-011 SHALL have port wr_data, output, 8 bits: data of the current wr_strobe.
REQ-012 SHALL have ports dbg_index (input, 8 bits) and dbg_data (output, 8 bits): combinational register readback; dbg_data = 0 when dbg_index >= NO_OF_REG.

Function
REQ-013 SHALL synchronise scl_i and sda_i each through two flops, then detect edges on the synchronised values.
REQ-014 SHALL detect START (incl. repeated START) as synchronised SDA falling while synchronised SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL sample SDA on each SCL rising edge, and SHALL change sda_oen only on SCL falling edges, within 3 pclk of the scl_i fall.
REQ-016 SHALL shift bits MSB first and count bits 0..7 per byte, with the ninth clock being the ACK slot.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 In every state, START SHALL go to ADDR and STOP SHALL go to IDLE, releasing sda_oen in the same cycle; START takes priority in the impossible simultaneous case.
REQ-019 In ADDR, after 8 bits: on address match, SHALL ACK (sda_oen=1 for the ninth clock) and latch R/W; on mismatch, SHALL go to IGNORE without driving SDA.
REQ-020 After ADDR_ACK, write (R/W=0) SHALL go to REG, and read (R/W=1) SHALL go to RD_DATA.
REQ-021 In REG, a received byte < NO_OF_REG SHALL load the pointer and be ACKed, then go to WR_DATA.
REQ-022 In REG, a received byte >= NO_OF_REG SHALL be NACKed, leave the pointer unchanged, and go to IGNORE.
REQ-023 In WR_DATA, each received byte SHALL:
- write reg[pointer];
- pulse wr_strobe with wr_index = pointer and wr_data = byte, in the cycle the eighth bit is sampled;
- be ACKed;
- increment the pointer, wrapping NO_OF_REG-1 -> 0.
REQ-024 In RD_DATA, SHALL drive reg[pointer] MSB first: the first bit on the falling edge ending the ACK slot, the following bits on successive SCL falls.
REQ-025 For each read bit, sda_oen SHALL equal the inverse of the data bit.
REQ-026 After each read byte, SHALL release SDA for the ACK slot and sample the master's ACK/NACK.
REQ-027 On master ACK, SHALL increment the pointer (with wrap) and continue RD_DATA.
REQ-028 On master NACK, SHALL increment the pointer and go to IGNORE.
REQ-029 In IGNORE, SHALL keep sda_oen=0 and wait only for START or STOP.
REQ-030 The pointer and register contents SHALL persist across START/STOP, so write-register-then-repeated-START-read works.

Reset
REQ-031 On areset low: state=IDLE, sda_oen=0, busy=0, wr_strobe=0, wr_index=0, wr_data=0, pointer=0, all registers=0x00, synchronisers=1.
REQ-032 A reset asserted mid-transfer SHALL release SDA immediately (asynchronously).
REQ-033 After reset release, the block SHALL wait for a fresh START and ignore bus activity until one is seen.

Verification
REQ-034 Write: START, 0xD0, 0x01, 0xA5, STOP -> ACK on three ninth clocks; wr_strobe once with index 1/data 0xA5; dbg_index=1 gives 0xA5.
REQ-035 Combined read: after REQ-034, START, 0xD0, 0x01, repeated START, 0xD1, master ACK then NACK, STOP -> bytes 0xA5 then reg[2]=0x00 driven; SDA released after the NACK.
REQ-036 Mismatch: START, 0xD8 (address 0x6C), 0x55, STOP -> sda_oen stays 0 throughout; no wr_strobe; busy 1 then 0.
REQ-037 Range/wrap: register byte 0x07 -> NACK, no write; register byte 0x03 with data 0x11, 0x22 -> reg[3]=0x11, reg[0]=0x22 (wrap).
REQ-038 Reset mid-read: areset low during bit 4 of a read byte -> sda_oen=0 at once; all registers 0; next valid write transaction completes normally.
